// File: rtl/spi_config_bridge.sv
// spi_config_bridge: SPI mode-0 slave front end for the 8 x 16-bit configuration register file.
// Every host signal is oversampled in the clk domain. A frame is 20 bits, sent MSB first:
// {rw, addr[2:0], data[15:0]}, where rw = 1 means write. A write frame ends in a single-cycle
// cfg_write strobe. A read frame shifts cfg_rdata back out on miso.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   sclk       host serial clock (asynchronous to clk)
//   csn        host chip select, active-low
//   mosi       host serial data in
//   miso       serial read data out (0 when not returning read data)
//   cfg_write  one-clk write strobe to the register file
//   cfg_addr   register address, holds between frames
//   cfg_wdata  register write data, holds between frames
//   cfg_rdata  register file output for cfg_addr
//   busy       high while a frame is in progress
//   frame_err  one-clk pulse when csn rises before a full frame was received
module spi_config_bridge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              csn,
  input  logic              mosi,
  output logic              miso,
  output logic              cfg_write,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_wdata,
  input  logic [DATA_W-1:0] cfg_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned HdrLen   = 1 + ADDR_W;
  localparam int unsigned FrameLen = HdrLen + DATA_W;
  localparam int unsigned CntW     = $clog2(FrameLen + 1);

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StLoad,
    StData,
    StCommit,
    StWaitCs
  } state_e;

  // Synchronizers. The top bit of the sclk/csn chains is the extra copy used for edge detection.
  logic [SYNC_STAGES:0]   sclk_sync_q;
  logic [SYNC_STAGES:0]   csn_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  // Fills with ones after reset. Until it is full, the csn chain still holds reset values, so a
  // csn that was already low when reset released does not look like a falling edge.
  logic [SYNC_STAGES:0]   vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      vld_q       <= '0;
    end else begin
      sclk_sync_q[0] <= sclk;
      csn_sync_q[0]  <= csn;
      mosi_sync_q[0] <= mosi;
      vld_q[0]       <= 1'b1;
      for (int i = 1; i <= SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        csn_sync_q[i]  <= csn_sync_q[i-1];
        vld_q[i]       <= vld_q[i-1];
      end
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
    end
  end

  logic sclk_s, csn_s, mosi_s;
  logic sclk_rise, sclk_fall, csn_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_sync_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_s & sclk_sync_q[SYNC_STAGES];
  assign csn_fall  = (&vld_q) & csn_sync_q[SYNC_STAGES] & ~csn_s;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] rd_shift_q, rd_shift_d;
  logic              cfg_write_q, cfg_write_d;
  logic              frame_err_q, frame_err_d;
  logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
  logic [DATA_W-1:0] cfg_wdata_q, cfg_wdata_d;

  logic [DATA_W-1:0] shift_in;
  logic [ADDR_W:0]   hdr;

  assign shift_in = {shift_q, mosi_s};
  assign hdr      = shift_in[ADDR_W:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    rd_shift_d  = rd_shift_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    cfg_write_d = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (csn_fall) begin
          state_d = StHeader;
          cnt_d   = '0;
        end
      end

      StHeader: begin
        if (csn_s) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          shift_d = shift_in[DATA_W-2:0];
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(HdrLen - 1)) begin
            rw_d       = hdr[ADDR_W];
            cfg_addr_d = hdr[ADDR_W-1:0];
            state_d    = StLoad;
          end
        end
      end

      // cfg_addr settled last cycle, so cfg_rdata now belongs to the addressed register.
      StLoad: begin
        if (csn_s) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end else begin
          rd_shift_d = rw_q ? '0 : cfg_rdata;
          state_d    = StData;
        end
      end

      StData: begin
        if (csn_s) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
          rd_shift_d  = '0;
        end else if (sclk_rise) begin
          shift_d = shift_in[DATA_W-2:0];
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(FrameLen - 1)) begin
            if (rw_q) begin
              cfg_wdata_d = shift_in;
              cfg_write_d = 1'b1;
              state_d     = StCommit;
            end else begin
              state_d = StWaitCs;
            end
          end
        end else if (sclk_fall && cnt_q > CntW'(HdrLen)) begin
          // The falling edge right after the last header bit is skipped. The freshly loaded MSB
          // must stay on miso until the host samples it on the next rising edge.
          rd_shift_d = rd_shift_q << 1;
        end
      end

      StCommit: begin
        state_d = StWaitCs;
      end

      StWaitCs: begin
        if (csn_s) begin
          state_d    = StIdle;
          rd_shift_d = '0;
        end
      end

      default: begin
        state_d    = StIdle;
        rd_shift_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      rd_shift_q  <= '0;
      cfg_write_q <= 1'b0;
      frame_err_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      rd_shift_q  <= rd_shift_d;
      cfg_write_q <= cfg_write_d;
      frame_err_q <= frame_err_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
    end
  end

  // The shifter is cleared on write frames and on every return to idle, so the flop output
  // can drive miso directly.
  assign miso      = rd_shift_q[DATA_W-1];
  assign cfg_write = cfg_write_q;
  assign frame_err = frame_err_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_wdata = cfg_wdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_config_bridge.sv
// Self-checking bench for spi_config_bridge. The bench plays the SPI host, and it also
// models the register file that sits downstream of the bridge.
module tb_spi_config_bridge;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        csn;
  logic        mosi;
  logic        miso;
  logic        cfg_write;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        busy;
  logic        frame_err;

  spi_config_bridge #(
    .SYNC_STAGES(S),
    .ADDR_W     (3),
    .DATA_W     (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .csn      (csn),
    .mosi     (mosi),
    .miso     (miso),
    .cfg_write(cfg_write),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Downstream register file. It is written by the DUT strobe and read combinationally.
  logic [15:0] regfile [8];
  assign cfg_rdata = regfile[cfg_addr];

  // Reference model state. It is updated only from the frames the host sends.
  logic [15:0] ref_mem [8];
  logic [2:0]  exp_addr;
  logic [15:0] exp_wdata;
  longint      t20;

  // Observations collected by the monitor.
  int          wr_cnt = 0;
  int          err_cnt = 0;
  logic [2:0]  last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare process.
  initial begin
    logic prev_wr;
    logic prev_err;
    logic lat_ok;
    for (int i = 0; i < 8; i++) regfile[i] = 16'h0000;
    regfile[0] = 16'hFFFF;
    regfile[4] = 16'hABCD;
    regfile[7] = 16'h0001;
    prev_wr  = 1'b0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy) begin
        check("idle_miso", 32'(miso), 32'd0);
        check("held_addr", 32'(cfg_addr), 32'(exp_addr));
        check("held_wdata", 32'(cfg_wdata), 32'(exp_wdata));
      end
      if (cfg_write) begin
        lat_ok = (($time - t20) <= longint'((S + 3) * 10 + 5));
        check("write_pulse_single", 32'(prev_wr), 32'd0);
        check("write_while_busy", 32'(busy), 32'd1);
        check("write_latency", 32'(lat_ok), 32'd1);
        if (!prev_wr) begin
          wr_cnt++;
          last_wr_addr = cfg_addr;
          last_wr_data = cfg_wdata;
          regfile[cfg_addr] = cfg_wdata;
        end
      end
      if (frame_err) begin
        check("err_pulse_single", 32'(prev_err), 32'd0);
        if (!prev_err) err_cnt++;
      end
      prev_wr  = cfg_write;
      prev_err = frame_err;
    end
  end

  // Sends the low nbits of word, MSB first. If reset_at >= 0, reset pulses before that bit.
  task automatic send_frame(input logic [31:0] word, input int nbits, input int reset_at,
                            output logic [15:0] rd);
    int          wr0;
    int          err0;
    int          half;
    bit          discarded;
    logic [31:0] al;
    logic        rw;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        exp_wr;
    logic        exp_err;
    wr0       = wr_cnt;
    err0      = err_cnt;
    discarded = 1'b0;
    rd        = '0;
    al        = word << (32 - nbits);
    rw        = al[31];
    addr      = al[30:28];
    data      = al[27:12];
    csn = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == reset_at) begin
        reset     = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        discarded = 1'b1;
        #25;
        reset = 1'b1;
      end
      mosi = word[nbits-1-i];
      half = 60 + int'($urandom_range(0, 25));
      #(half);
      if (i >= 4 && i < 20) rd[19-i] = miso;
      sclk = 1'b1;
      if (i == 19) t20 = $time;
      #(half);
      sclk = 1'b0;
    end
    #(65);
    csn = 1'b1;
    if (!discarded) begin
      if (nbits >= 4) exp_addr = addr;
      if (nbits >= 20 && rw) begin
        exp_wdata     = data;
        ref_mem[addr] = data;
      end
    end
    #((S + 4) * 10 + 7);
    exp_wr  = !discarded && nbits >= 20 && rw;
    exp_err = !discarded && nbits < 20;
    check("write_count", 32'(wr_cnt - wr0), 32'(exp_wr));
    check("err_count", 32'(err_cnt - err0), 32'(exp_err));
    check("busy_after_cs", 32'(busy), 32'd0);
    if (exp_wr) begin
      check("wr_addr", 32'(last_wr_addr), 32'(addr));
      check("wr_data", 32'(last_wr_data), 32'(data));
    end
    if (!discarded && nbits >= 20 && !rw) check("read_data", 32'(rd), 32'(ref_mem[addr]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [31:0] al;
    int          nb;
    reset = 1'b0;
    csn   = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    t20       = 0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
    ref_mem[0] = 16'hFFFF;
    ref_mem[4] = 16'hABCD;
    ref_mem[7] = 16'h0001;

    #22;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg_write", 32'(cfg_write), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_cfg_addr", 32'(cfg_addr), 32'd0);
    check("rst_cfg_wdata", 32'(cfg_wdata), 32'd0);
    reset = 1'b1;
    #53;

    // Basic write.
    send_frame({12'd0, 1'b1, 3'd5, 16'h1234}, 20, -1, rd);
    check("lit_wr5_addr", 32'(last_wr_addr), 32'd5);
    check("lit_wr5_data", 32'(last_wr_data), 32'h1234);

    // Reads of the register file defaults.
    send_frame({12'd0, 1'b0, 3'd4, 16'h0000}, 20, -1, rd);
    check("lit_rd4", 32'(rd), 32'hABCD);
    send_frame({12'd0, 1'b0, 3'd0, 16'h5555}, 20, -1, rd);
    check("lit_rd0", 32'(rd), 32'hFFFF);
    send_frame({12'd0, 1'b0, 3'd7, 16'h0000}, 20, -1, rd);
    check("lit_rd7", 32'(rd), 32'h0001);

    // Write then read back, with no leakage into a neighbouring register.
    send_frame({12'd0, 1'b1, 3'd2, 16'hA5A5}, 20, -1, rd);
    send_frame({12'd0, 1'b0, 3'd2, 16'h0000}, 20, -1, rd);
    check("lit_rd2", 32'(rd), 32'hA5A5);
    send_frame({12'd0, 1'b0, 3'd3, 16'h0000}, 20, -1, rd);
    check("lit_rd3", 32'(rd), 32'h0000);

    // Short frame aborts, and the next frame is still accepted.
    send_frame({20'd0, 1'b1, 3'd3, 8'h5A}, 12, -1, rd);
    check("lit_short_addr", 32'(cfg_addr), 32'd3);
    send_frame({12'd0, 1'b1, 3'd6, 16'h0F0F}, 20, -1, rd);
    check("lit_wr6_data", 32'(last_wr_data), 32'h0F0F);

    // Trailing bits after a complete write are ignored.
    send_frame({8'd0, 1'b1, 3'd1, 16'h00FF, 4'hA}, 24, -1, rd);
    check("lit_long_addr", 32'(last_wr_addr), 32'd1);
    check("lit_long_data", 32'(last_wr_data), 32'h00FF);

    // Reset mid-frame while csn stays low discards the rest of the frame.
    send_frame({12'd0, 1'b1, 3'd5, 16'hBEEF}, 20, 10, rd);
    check("lit_after_rst_addr", 32'(cfg_addr), 32'd0);
    check("lit_after_rst_wdata", 32'(cfg_wdata), 32'd0);
    send_frame({12'd0, 1'b0, 3'd5, 16'h0000}, 20, -1, rd);
    check("lit_rd5", 32'(rd), 32'h1234);

    // Randomised mix of reads, writes, short and long frames.
    for (int n = 0; n < 25; n++) begin
      int r;
      r  = int'($urandom_range(0, 9));
      if (r < 6) nb = 20;
      else if (r < 8) nb = int'($urandom_range(21, 24));
      else nb = int'($urandom_range(1, 19));
      al = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), 12'($urandom)};
      send_frame(al >> (32 - nb), nb, -1, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
